// File: rtl/wb_stage_if.sv
// wb_stage_if: result handshakes, issue/scoreboard inputs, decode hazard outputs and register-file write port
interface wb_stage_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            issue_valid;
  logic            issue_long;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_fwd;
  logic            rs2_fwd;
  logic [4:0]      rd;
  logic            reg_wen;
  logic [XLEN-1:0] data_in;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_long, issue_rd, rs1, rs2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
           rd, reg_wen, data_in
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_long, issue_rd, rs1, rs2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
           rd, reg_wen, data_in
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback arbiter (mem over ALU) with long-latency scoreboard and decode hazard/bypass; WB_BYPASS_EN enables forwarding
module wb_stage #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  logic [4:0]      r_rd;
  logic            r_wen;
  logic [XLEN-1:0] r_data;
  logic [31:1]     r_pend;
  logic            w_mem_acc;
  logic            w_alu_acc;
  logic            w_acc;
  logic [4:0]      w_src_rd;
  logic [XLEN-1:0] w_src_data;
  logic [31:1]     w_pend_nxt;
  logic [31:0]     w_pend;
  logic            w_hit1;
  logic            w_hit2;
  // Fixed-priority accept: a valid memory result always wins, the ALU waits
  always_comb begin
    w_mem_acc  = bus.mem_valid && !rst;
    w_alu_acc  = bus.alu_valid && !rst && !bus.mem_valid;
    w_acc      = w_mem_acc || w_alu_acc;
    w_src_rd   = w_mem_acc ? bus.mem_rd : bus.alu_rd;
    w_src_data = w_mem_acc ? bus.mem_data : bus.alu_data;
  end
  // Next scoreboard: a new long issue to rd overrides a same-cycle memory completion of rd
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 1; i < 32; i++)
      w_pend_nxt[i] = (bus.issue_valid && bus.issue_long && bus.issue_rd == 5'(i)) ||
                      (r_pend[i] && !(w_mem_acc && bus.mem_rd == 5'(i)));
  end
  assign w_pend = {r_pend, 1'b0};
  assign w_hit1 = r_wen && (r_rd == bus.rs1) && (bus.rs1 != 5'd0);
  assign w_hit2 = r_wen && (r_rd == bus.rs2) && (bus.rs2 != 5'd0);
  assign bus.mem_ready = !rst;
  assign bus.alu_ready = !rst && !bus.mem_valid;
  assign bus.rd        = r_rd;
  assign bus.reg_wen   = r_wen;
  assign bus.data_in   = r_data;
`ifdef WB_BYPASS_EN
  assign bus.rs1_busy = !rst && w_pend[bus.rs1];
  assign bus.rs2_busy = !rst && w_pend[bus.rs2];
  assign bus.rs1_fwd  = !rst && w_hit1 && !w_pend[bus.rs1];
  assign bus.rs2_fwd  = !rst && w_hit2 && !w_pend[bus.rs2];
`else
  assign bus.rs1_busy = !rst && (w_pend[bus.rs1] || w_hit1);
  assign bus.rs2_busy = !rst && (w_pend[bus.rs2] || w_hit2);
  assign bus.rs1_fwd  = 1'b0;
  assign bus.rs2_fwd  = 1'b0;
`endif
  // Register the accepted result; rd/data hold when idle, x0 completes without a write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_pend <= '0;
    end else begin
      r_wen  <= w_acc && (w_src_rd != 5'd0);
      r_rd   <= w_acc ? w_src_rd : r_rd;
      r_data <= w_acc ? w_src_data : r_data;
      r_pend <= w_pend_nxt;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven check of wb_stage arbitration, scoreboard, hazards and reset
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  wb_stage_if #(.XLEN(32)) bus();
  wb_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        iv;
    logic        il;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  rdy;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [3:0]  hb;
    logic [3:0]  hn;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic r, av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic iv, il, input logic [4:0] ird, rs1, rs2,
                     input logic [1:0] rdy, input logic wen, input logic [4:0] rd,
                     input logic [31:0] d, input logic [3:0] hb, hn);
    vec_t t;
    t.r = r; t.av = av; t.ard = ard; t.ad = ad; t.mv = mv; t.mrd = mrd; t.md = md;
    t.iv = iv; t.il = il; t.ird = ird; t.rs1 = rs1; t.rs2 = rs2;
    t.rdy = rdy; t.wen = wen; t.rd = rd; t.d = d; t.hb = hb; t.hn = hn;
    vq.push_back(t);
  endtask
  task automatic drive(input vec_t t);
    rst = t.r;
    bus.alu_valid = t.av; bus.alu_rd = t.ard; bus.alu_data = t.ad;
    bus.mem_valid = t.mv; bus.mem_rd = t.mrd; bus.mem_data = t.md;
    bus.issue_valid = t.iv; bus.issue_long = t.il; bus.issue_rd = t.ird;
    bus.rs1 = t.rs1; bus.rs2 = t.rs2;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  initial begin
    vec_t z;
    logic [3:0] eh;
    z = '{default: '0};
    z.r = 1'b1;
    drive(z);
    repeat (2) @(posedge clk);
    //  r av ard ad            mv mrd md            iv il ird rs1 rs2  rdy    wen rd  data          byp      nobyp
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 0,  32'h0,        4'b0000, 4'b0000);
    add(0, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 0,  32'h0,        4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  5,  0,  2'b11, 1, 5,  32'hDEADBEEF, 4'b0010, 4'b1000);
    add(0, 1, 3, 32'h11,       1, 4,  32'h22,       0, 0, 0,  5,  5,  2'b01, 0, 5,  32'hDEADBEEF, 4'b0000, 4'b0000);
    add(0, 1, 3, 32'h11,       0, 0,  32'h0,        0, 0, 0,  4,  3,  2'b11, 1, 4,  32'h22,       4'b0010, 4'b1000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  3,  3,  2'b11, 1, 3,  32'h11,       4'b0011, 4'b1100);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 7,  0,  7,  2'b11, 0, 3,  32'h11,       4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  0,  7,  2'b11, 0, 3,  32'h11,       4'b0100, 4'b0100);
    add(0, 0, 0, 32'h0,        1, 7,  32'h77,       1, 1, 7,  0,  7,  2'b01, 0, 3,  32'h11,       4'b0100, 4'b0100);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  0,  7,  2'b11, 1, 7,  32'h77,       4'b0100, 4'b0100);
    add(0, 0, 0, 32'h0,        1, 7,  32'h78,       0, 0, 0,  0,  7,  2'b01, 0, 7,  32'h77,       4'b0100, 4'b0100);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  7,  7,  2'b11, 1, 7,  32'h78,       4'b0011, 4'b1100);
    add(0, 1, 0, 32'h5,        0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 7,  32'h78,       4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 0,  32'h5,        4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 9,  9,  0,  2'b11, 0, 0,  32'h5,        4'b0000, 4'b0000);
    add(1, 0, 0, 32'h0,        1, 9,  32'h99,       0, 0, 0,  9,  0,  2'b00, 0, 0,  32'h5,        4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  9,  0,  2'b11, 0, 0,  32'h0,        4'b0000, 4'b0000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 0,  0,  0,  2'b11, 0, 0,  32'h0,        4'b0000, 4'b0000);
    add(0, 1, 1, 32'hA1,       0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 0,  32'h0,        4'b0000, 4'b0000);
    add(0, 1, 2, 32'hA2,       0, 0,  32'h0,        0, 0, 0,  1,  0,  2'b11, 1, 1,  32'hA1,       4'b0010, 4'b1000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  2,  1,  2'b11, 1, 2,  32'hA2,       4'b0010, 4'b1000);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0,  0,  0,  2'b11, 0, 2,  32'hA2,       4'b0000, 4'b0000);
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
`ifdef WB_BYPASS_EN
      eh = vq[i].hb;
`else
      eh = vq[i].hn;
`endif
      chk($sformatf("v%0d ready", i), 64'({bus.alu_ready, bus.mem_ready}), 64'(vq[i].rdy));
      chk($sformatf("v%0d write", i), 64'({bus.reg_wen, bus.rd, bus.data_in}),
          64'({vq[i].wen, vq[i].rd, vq[i].d}));
      chk($sformatf("v%0d hazard", i), 64'({bus.rs1_busy, bus.rs2_busy, bus.rs1_fwd, bus.rs2_fwd}), 64'(eh));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      z = '{default: '0};
      z.av = 1'b1; z.ard = 5'd6; z.ad = 32'h66;
      z.mv = 1'b1; z.mrd = 5'(10 + i); z.md = 32'(100 + i);
      drive(z);
      #1;
      chk($sformatf("stall%0d alu_ready", i), 64'(bus.alu_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d mem write", i), 64'({bus.reg_wen, bus.rd, bus.data_in}),
          64'({1'b1, 5'(10 + i), 32'(100 + i)}));
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    chk("stall release alu_ready", 64'(bus.alu_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("stalled alu write", 64'({bus.reg_wen, bus.rd, bus.data_in}), 64'({1'b1, 5'd6, 32'h66}));
    @(negedge clk);
    bus.alu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle after stall", 64'(bus.reg_wen), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32 core, directly upstream of the 32x32 register file write port. Accepts completed results from the single-cycle ALU path and the long-latency memory/load path over valid/ready handshakes. Arbitrates them into one registered write (`rd`, `reg_wen`, `data_in`) per cycle. Also keeps a per-register pending scoreboard for long-latency destinations and provides hazard and bypass information to decode for the two register-file read addresses.

## Interface
- `XLEN`, 32: data width of results and write data.
- `clk`  input  1  core clock; all state updates on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `alu_valid`  input  1  ALU result valid.
- `alu_rd`  input  5  ALU destination register.
- `alu_data`  input  XLEN  ALU result.
- `alu_ready`  output  1  ALU result accepted this cycle when high with `alu_valid`.
- `mem_valid`  input  1  memory/long-latency result valid.
- `mem_rd`  input  5  memory destination register.
- `mem_data`  input  XLEN  memory result.
- `mem_ready`  output  1  memory result accepted when high with `mem_valid`.
- `issue_valid`  input  1  decode issuing an instruction this cycle.
- `issue_long`  input  1  issued instruction completes via the memory path.
- `issue_rd`  input  5  destination of the issued instruction.
- `rs1`, `rs2`  input  5 each  decode read addresses, shared with the register file.
- `rs1_busy`, `rs2_busy`  output  1 each  operand not yet available; decode must stall.
- `rs1_fwd`, `rs2_fwd`  output  1 each  select `data_in` instead of the register-file read data.
- `rd`  output  5  register file write address.
- `reg_wen`  output  1  register file write enable.
- `data_in`  output  XLEN  register file write data.

## Operation
- Arbitration is fixed priority, memory first.
  - `mem_ready` = !rst.
  - `alu_ready` = !rst && !mem_valid.
- Accepted result is captured into the output register: `rd` <= src_rd, `data_in` <= src_data, `reg_wen` <= (src_rd != 0).
- No accept in a cycle: `reg_wen` <= 0. `rd` and `data_in` hold their values.
- Destination x0: the handshake completes and `reg_wen` stays 0. Scoreboard bit 0 is never set.
- Scoreboard `pending[31:1]`:
  - Set on `issue_valid && issue_long && issue_rd != 0`.
  - Cleared when a memory result for that rd is accepted.
  - Set and clear of the same rd in one cycle: set wins.
- Decode must not issue a long op whose `issue_rd` is already pending. The block does not check this.
- `rsN_busy` = (rsN != 0) && `pending[rsN]`. Combinational, from current state.
- `rsN_fwd` = `reg_wen` && (`rd` == rsN) && (rsN != 0) && !`rsN_busy`.

## Timing
- Result latency: accepted in cycle N -> `reg_wen`/`rd`/`data_in` driven in N+1 -> register file updated at end of N+1 -> readable from the file in N+2. Bypass covers N+1.
- Scoreboard: set at the issue edge, so busy is visible the next cycle. Cleared at the mem-accept edge. In N+1 the value is then supplied via `rsN_fwd`.
- Handshake: a transfer occurs on the edge where valid && ready. Sources hold their data while valid && !ready. `alu_valid` may stall indefinitely while `mem_valid` stays high.
- Reset (any cycle, including mid-transfer):
  - `reg_wen`=0, `rd`=0, `data_in`=0, `pending`=0.
  - `alu_ready`=`mem_ready`=0 while `rst` is high. Busy/fwd outputs read 0.
  - In-flight handshakes are dropped.
- Back-to-back accepts are sustained at one per cycle.

## Configuration
- `WB_BYPASS_EN` defined: forwarding as described.
- `WB_BYPASS_EN` undefined:
  - `rs1_fwd`/`rs2_fwd` tied 0.
  - `rsN_busy` also asserts when `reg_wen` && (`rd` == rsN) && rsN != 0.
  - Effect: decode stalls one cycle instead of forwarding.

## Test plan
- Reset then idle: `reg_wen`=0, `rd`=0, `data_in`=0, `alu_ready`=1, `mem_ready`=1, all busy/fwd=0.
- ALU valid, rd=5, data=0xDEADBEEF at cycle N -> cycle N+1 `reg_wen`=1, `rd`=5, `data_in`=0xDEADBEEF. With rs1=5 in N+1: `rs1_fwd`=1 (bypass build), or `rs1_busy`=1 (no-bypass build).
- ALU (rd=3, 0x11) and mem (rd=4, 0x22) valid together -> `alu_ready`=0. Next cycle writes rd=4/0x22; the following cycle writes rd=3/0x11.
- Issue long rd=7 -> `rs2_busy`=1 for rs2=7 until mem rd=7 accepted. Same-cycle issue of rd=7 and mem accept of rd=7 -> pending[7] remains 1.
- ALU result to rd=0 with data 0x5 -> handshake completes, `reg_wen`=0. rs1=0 never busy or forwarded.
- Assert `rst` while mem valid and pending[9]=1 -> next cycle all outputs zero, pending cleared, no write issued.
